// File: rtl/mem_refill_arbiter.sv
// Purpose : shares one word-wide memory port between the I-cache refill path and
//           the D-cache refill/write-back path, running whole-line bursts picked
//           by round-robin and emitting per-beat strobes and completion pulses.
// Latency : request sampled in IDLE at edge N -> mem_valid from cycle N+1;
//           with mem_ready tied high a grant costs 1 + LINE_WORDS + 1 cycles.
// Backpressure: mem_ready low stalls the burst; every output holds, no timeout.
//
// Ports
//   CPU_CLK, CPU_RST            : clock, synchronous active-high reset
//   i_req/i_addr                : I-side line refill request (held until i_done)
//   i_rvalid/i_beat/i_rdata     : I-side read beat strobe, beat index, read word
//   i_done                      : one-cycle I-side burst completion pulse
//   d_req/d_we/d_addr/d_wdata   : D-side request (1 = write-back), write word
//   d_rvalid/d_wack/d_beat      : D-side read strobe / write accept / beat index
//   d_rdata/d_done              : D-side read word, completion pulse
//   mem_valid/mem_we/mem_addr/mem_wdata/mem_ready/mem_rdata : memory port
module mem_refill_arbiter #(
  parameter int unsigned LINE_WORDS = 4,  // power of two, 2..16
  parameter int unsigned BEAT_W     = 2   // log2(LINE_WORDS)
) (
  input  logic              CPU_CLK,
  input  logic              CPU_RST,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_rvalid,
  output logic [BEAT_W-1:0] i_beat,
  output logic [31:0]       i_rdata,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_rvalid,
  output logic              d_wack,
  output logic [BEAT_W-1:0] d_beat,
  output logic [31:0]       d_rdata,
  output logic              d_done,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata
);

  // Byte-address mask that clears the word-in-line and byte-in-word bits.
  localparam logic [31:0]       LINE_MASK = ~(32'(LINE_WORDS * 4) - 32'd1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  owner_t            last_owner_q, last_owner_d;
  logic              we_q, we_d;
  logic [31:0]       base_q, base_d;
  logic [BEAT_W-1:0] beat_q, beat_d;

  logic in_burst;
  logic in_done;
  logic grant_d;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    base_d       = base_q;
    beat_d       = beat_q;
    // D wins when it is the only requester, or on a tie when I was served last.
    grant_d      = d_req & (~i_req | (last_owner_q == OWN_I));

    case (state_q)
      ST_IDLE: begin
        if (i_req | d_req) begin
          owner_d = grant_d ? OWN_D : OWN_I;
          // The I side only ever refills, so its direction is forced to read.
          we_d    = grant_d & d_we;
          base_d  = (grant_d ? d_addr : i_addr) & LINE_MASK;
          beat_d  = '0;
          state_d = ST_BURST;
        end
      end

      ST_BURST: begin
        // mem_valid is constantly high here, so mem_ready alone is the handshake.
        if (mem_ready) begin
          // Beat counter wraps naturally at LINE_WORDS; it never touches base.
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            state_d      = ST_DONE;
            last_owner_d = owner_q;
          end
        end
      end

      ST_DONE: begin
        // Requests are ignored for this cycle so the winner can release req.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CPU_CLK) begin
    if (CPU_RST) begin
      // An in-flight burst is simply abandoned; no done pulse follows.
      state_q      <= ST_IDLE;
      owner_q      <= OWN_I;
      last_owner_q <= OWN_I;
      we_q         <= 1'b0;
      base_q       <= '0;
      beat_q       <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      base_q       <= base_d;
      beat_q       <= beat_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: decoded from registered state; beat strobes also follow mem_ready
  // because a read word is only valid in the cycle memory accepts the beat.
  // --------------------------------------------------------------------------
  always_comb begin
    in_burst = (state_q == ST_BURST);
    in_done  = (state_q == ST_DONE);

    // Memory-side fields are zeroed outside a burst so idle cycles are quiet.
    mem_valid = in_burst;
    mem_we    = in_burst & we_q;
    mem_addr  = in_burst ? (base_q + {{(30 - BEAT_W){1'b0}}, beat_q, 2'b00}) : 32'd0;
    mem_wdata = in_burst ? d_wdata : 32'd0;

    i_rvalid  = in_burst & (owner_q == OWN_I) & mem_ready;
    d_rvalid  = in_burst & (owner_q == OWN_D) & ~we_q & mem_ready;
    d_wack    = in_burst & (owner_q == OWN_D) &  we_q & mem_ready;

    i_beat    = (owner_q == OWN_I) ? beat_q : '0;
    d_beat    = (owner_q == OWN_D) ? beat_q : '0;

    i_done    = in_done & (owner_q == OWN_I);
    d_done    = in_done & (owner_q == OWN_D);

    i_rdata   = mem_rdata;
    d_rdata   = mem_rdata;
  end

endmodule

// File: doc/mem_refill_arbiter.md
# mem_refill_arbiter

Sequential arbiter and burst sequencer that shares one word-wide main-memory port between the instruction-cache refill path and the data-cache refill/write-back path of the RV32 pipeline core. It runs whole cache-line bursts, chosen by round-robin, and produces the per-beat strobes and completion pulses. The cache controllers use these pulses to drop their `ICacheMiss`/`DCacheMiss` stall requests to the hazard unit.

## Interface
- `LINE_WORDS`, default 4: words per cache line; must be a power of two, 2..16.
- `BEAT_W`, default 2: log2(LINE_WORDS).
- `CPU_CLK`  in  1  single clock; all state updates on the rising edge.
- `CPU_RST`  in  1  reset, synchronous and active-high.
- `i_req`  in  1  I-side line-refill request; held until `i_done`.
- `i_addr`  in  32  I-side line address; bits [BEAT_W+1:0] are ignored.
- `i_rvalid`  out  1  I-side read beat valid.
- `i_beat`  out  BEAT_W  index of the current I-side beat.
- `i_rdata`  out  32  passthrough of `mem_rdata`.
- `i_done`  out  1  one-cycle pulse when the I-side burst completes.
- `d_req`  in  1  D-side request; held until `d_done`.
- `d_we`  in  1  D-side direction: 1 = write-back, 0 = refill.
- `d_addr`  in  32  D-side line address; low bits ignored as for `i_addr`.
- `d_wdata`  in  32  write word for the beat given by `d_beat`.
- `d_rvalid`, `d_wack`  out  1 each  D-side read beat valid / write beat accepted.
- `d_beat`  out  BEAT_W  index of the current D-side beat.
- `d_rdata`  out  32  passthrough of `mem_rdata`.
- `d_done`  out  1  one-cycle pulse when the D-side burst completes.
- `mem_valid`  out  1  memory beat request.
- `mem_we`  out  1  memory beat direction: 1 = write.
- `mem_addr`  out  32  memory word address.
- `mem_wdata`  out  32  memory write word.
- `mem_ready`  in  1  beat accepted; for reads, `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  32  memory read word.

## Operation
- **States:** IDLE, BURST, DONE. Registers: `owner` (I/D), `we_r`, `base_r` (line-aligned), `beat` (BEAT_W bits), `last_owner`.
- **IDLE:**
  - If neither request is active, stay in IDLE.
  - If exactly one request is active, grant it.
  - If both are active, grant the side that is not `last_owner`. `last_owner` resets to I, so D wins the first tie.
  - On a grant: latch `base_r = addr & ~(LINE_WORDS*4-1)`, latch `we_r` (D only; forced to 0 for I), set `beat=0`, go to BURST.
- **BURST:**
  - `mem_valid=1`, `mem_we=we_r`, `mem_addr = base_r + {beat,2'b00}`, `mem_wdata = d_wdata`.
  - When `mem_valid & mem_ready`: the beat is accepted and `beat` increments.
  - On the accepted beat where `beat == LINE_WORDS-1`: go to DONE, set `last_owner = owner`.
  - While `mem_ready=0`, all outputs hold; there is no timeout.
- **DONE:** `owner`'s `x_done=1` for exactly one cycle, `mem_valid=0`, requests ignored, then go to IDLE.
- **Beat strobes:**
  - `i_rvalid = BURST & owner==I & mem_ready`.
  - `d_rvalid = BURST & owner==D & !we_r & mem_ready`.
  - `d_wack = BURST & owner==D & we_r & mem_ready`.
  - `x_beat = beat` when `owner==x`, else 0.
- **Request changes mid-burst:** dropping the request or changing its address has no effect. The burst runs to completion on the latched values and `done` still pulses.
- **Address arithmetic:** `beat` wraps at LINE_WORDS and never carries into `base_r`. Beats are issued in ascending order only; there is no critical-word-first ordering.
- **Reset:** `CPU_RST` high at any edge forces IDLE, `beat=0`, `last_owner=I`. Reset mid-burst abandons the burst, and no `done` pulse is issued for it.

## Timing
- **Reset values (cycle after reset):** all outputs 0, including `mem_valid`, `mem_we`, `mem_addr`, `mem_wdata`, `x_rvalid`, `d_wack`, `x_done`, `x_beat`.
- **Request to first beat:** a request sampled in IDLE at edge N gives `mem_valid=1` from cycle N+1.
- **Burst length:** with `mem_ready` tied high, a grant takes 1 (IDLE) + LINE_WORDS (BURST) + 1 (DONE) cycles; this is 6 cycles for LINE_WORDS=4.
- **Back-to-back grants:** the earliest next grant is in the IDLE cycle following DONE, so there are at least 2 cycles between the last beat of one burst and the first beat of the next.
- **Release rule:** the requester must deassert `req` in its DONE cycle or earlier. A request still high in the next IDLE is treated as a new request.

## Test plan
- **Single I refill:** `i_req`, `i_addr=0x0000_1234`, `mem_ready=1` → `mem_addr` 0x1230, 0x1234, 0x1238, 0x123C on consecutive cycles; `i_beat` 0..3; `i_done` in cycle 6; `mem_we=0` throughout.
- **Tie, then alternation:** `i_req` and `d_req` rise together after reset → D served first, then I; a second simultaneous pair → D then I again (`last_owner` alternates correctly).
- **D write-back with wait states:** `d_we=1`, `d_addr=0x8000_0040`, `mem_ready` low every other cycle → exactly 4 `d_wack` pulses; `mem_wdata` equals `d_wdata` for beats 0..3; `d_done` one cycle after the 4th accept; total 10 cycles.
- **Mid-burst request changes:** drop `i_req` and change `i_addr` after beat 1 → beats 2 and 3 still go to the original line; `i_done` still pulses.
- **Reset mid-burst:** `CPU_RST` asserted after beat 2 of a D refill → `mem_valid=0` and `d_done=0` the next cycle; a new `i_req` is then granted first.
- **Held request after done:** `i_req` held high through DONE → a second burst starts, with `mem_valid` rising 2 cycles after `i_done`.
